// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the in-order writeback
// stage and the long-latency unit (LLU). It tracks registers with pending
// LLU results, stalls decode on hazards against them, and forces an LLU
// grant after a bounded number of denied cycles so the LLU cannot starve.
module regfile_wb_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wd,
    output logic        pipe_hold,

    input  logic        llu_valid,
    input  logic [4:0]  llu_rd,
    input  logic [31:0] llu_wd,
    output logic        llu_ready,

    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,

    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_rs1_used,
    input  logic        dec_rs2_used,
    input  logic        dec_we,
    output logic        dec_stall,

    output logic [4:0]  ad3,
    output logic [31:0] wd3,
    output logic        we3
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_FIRE = WAIT_W'(STARVE_LIMIT - 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arbState_e;

    arbState_e         state_q, state_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [31:0]       busy_q, busy_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;

    logic        pipeAct;
    logic        lluAct;
    logic        lluReadyInt;
    logic        pipeHoldInt;
    logic        issueReadyInt;
    logic        decStallInt;
    logic        doSet;
    logic        doClear;
    logic [4:0]  ad3Int;
    logic [31:0] wd3Int;
    logic        we3Int;

    // Writes to x0 are not real requests for either source.
    assign pipeAct = pipe_we & (pipe_rd != 5'd0);
    assign lluAct  = llu_valid & (llu_rd != 5'd0);

    // Arbiter FSM: writeback wins in NORMAL, the LLU is granted unconditionally for one FORCE cycle.
    always_comb begin
        state_d     = state_q;
        lluReadyInt = 1'b0;
        pipeHoldInt = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                lluReadyInt = llu_valid & ~pipeAct;
                if (llu_valid && !lluReadyInt && (waitCnt_q == WAIT_FIRE)) begin
                    state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                lluReadyInt = llu_valid;
                pipeHoldInt = 1'b1;
                state_d     = ST_NORMAL;
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase
    end

    // Starvation counter: counts consecutive denied LLU cycles and saturates rather than wrapping.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (!llu_valid || lluReadyInt) begin
            waitCnt_d = '0;
        end else if (waitCnt_q != WAIT_SAT) begin
            waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
    end

    // Write-port mux: a granted LLU result takes the port, otherwise an unheld pipe write.
    always_comb begin
        ad3Int = 5'd0;
        wd3Int = 32'd0;
        we3Int = 1'b0;
        if (lluReadyInt) begin
            ad3Int = llu_rd;
            wd3Int = llu_wd;
            we3Int = lluAct;
        end else if (pipeAct && !pipeHoldInt) begin
            ad3Int = pipe_rd;
            wd3Int = pipe_wd;
            we3Int = 1'b1;
        end
    end

    // Scoreboard: set on accepted issue, clear on LLU writeback of a busy register; x0 never busy.
    always_comb begin
        issueReadyInt = ~busy_q[issue_rd] & (outstanding_q < CNT_MAX);
        doSet         = issue_valid & issueReadyInt & (issue_rd != 5'd0);
        doClear       = lluReadyInt & lluAct & busy_q[llu_rd];

        busy_d = busy_q;
        if (doClear) begin
            busy_d[llu_rd] = 1'b0;
        end
        if (doSet) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        outstanding_d = outstanding_q;
        case ({doSet, doClear})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Hazard stall: any used operand or destination pending in the LLU, or a held pipe.
    always_comb begin
        decStallInt = (dec_rs1_used & busy_q[dec_rs1])
                    | (dec_rs2_used & busy_q[dec_rs2])
                    | (dec_we & busy_q[dec_rd])
                    | pipeHoldInt;
    end

    // State registers with synchronous active-low reset that drops all pending scoreboard state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_NORMAL;
            waitCnt_q     <= '0;
            busy_q        <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            waitCnt_q     <= waitCnt_d;
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
        end
    end

    // All outputs are held low while reset is asserted.
    assign pipe_hold   = rst_n & pipeHoldInt;
    assign llu_ready   = rst_n & lluReadyInt;
    assign issue_ready = rst_n & issueReadyInt;
    assign dec_stall   = rst_n & decStallInt;
    assign we3         = rst_n & we3Int;
    assign ad3         = rst_n ? ad3Int : 5'd0;
    assign wd3         = rst_n ? wd3Int : 32'd0;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Sharing controller for the single register-file write port (ad3/wd3/we3). Each cycle it picks between the in-order writeback stage and the long-latency unit (LLU: mul/div/load-miss) result port. It keeps a scoreboard of registers with pending LLU writes, stalls decode on RAW/WAW hazards against them, and bounds LLU starvation with a forced-grant cycle. Sits between the writeback stage, the LLU and the register file; decode reads its stall output.

## Interface
Parameters:
- MAX_OUTSTANDING, 4, max LLU ops issued but not yet written back (1..31)
- STARVE_LIMIT, 8, consecutive denied LLU cycles before a forced grant (≥1)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous reset, active-low
- pipe_we  in  1  writeback stage write request
- pipe_rd  in  5  writeback destination
- pipe_wd  in  32  writeback data
- pipe_hold  out  1  freeze writeback stage and everything upstream this cycle
- llu_valid  in  1  LLU result available
- llu_rd  in  5  LLU result destination
- llu_wd  in  32  LLU result data
- llu_ready  out  1  LLU result accepted this cycle
- issue_valid  in  1  decode wants to dispatch an op to the LLU
- issue_rd  in  5  destination of that op
- issue_ready  out  1  dispatch accepted
- dec_rs1, dec_rs2, dec_rd  in  5 each  decode operand/destination addresses
- dec_rs1_used, dec_rs2_used, dec_we  in  1 each  qualifiers for the above
- dec_stall  out  1  hazard stall to decode
- ad3  out  5  register-file write address
- wd3  out  32  register-file write data
- we3  out  1  register-file write enable

## Operation
- pipe_act = pipe_we & (pipe_rd != 0). llu_act = llu_valid & (llu_rd != 0).
- Arbiter FSM, states NORMAL and FORCE:
  - NORMAL: writeback has priority. llu_ready = llu_valid & !pipe_act. pipe_hold = 0.
  - FORCE: llu_ready = llu_valid, pipe_hold = 1, and the pipe write is not performed.
  - NORMAL→FORCE: at posedge when llu_valid & !llu_ready and wait_cnt == STARVE_LIMIT-1.
  - FORCE→NORMAL: always, after exactly one cycle.
- wait_cnt: clears on any cycle with llu_ready=1 or llu_valid=0. Increments on every cycle with llu_valid & !llu_ready. Saturates; never wraps.
- Write port, combinational: an LLU grant drives llu_rd/llu_wd with we3=llu_act. Otherwise the port drives pipe_rd/pipe_wd with we3=pipe_act & !pipe_hold. With no grant and no pipe write, ad3=0, wd3=0, we3=0.
- Scoreboard busy[31:0], with busy[0] hardwired to 0. outstanding counter holds 0..MAX_OUTSTANDING.
  - issue_ready = !busy[issue_rd] & (outstanding < MAX_OUTSTANDING), computed from registered state.
  - Accepted issue with issue_rd != 0 sets busy[issue_rd] and increments outstanding.
  - Issue with issue_rd = 0 is accepted with no scoreboard change.
  - llu_ready & llu_act clears busy[llu_rd] and decrements outstanding.
  - Set and clear in the same cycle hit different registers, because of the issue_ready rule. outstanding then stays unchanged.
  - An LLU result for a non-busy register is a protocol error. The write still happens; the scoreboard and counter are unchanged (no underflow).
- dec_stall = (dec_rs1_used & busy[dec_rs1]) | (dec_rs2_used & busy[dec_rs2]) | (dec_we & busy[dec_rd]) | pipe_hold. No bypass: the stall drops the cycle after the LLU write.
- LLU handshake: llu_valid and its payload are held stable until llu_ready. The arbiter never combinationally depends on llu_ready.

## Timing
- Reset (rst_n=0 at posedge):
  - State → NORMAL; busy and outstanding → 0; wait_cnt → 0.
  - While rst_n=0, all outputs are forced low: we3=0, ad3=0, wd3=0, llu_ready=0, issue_ready=0, pipe_hold=0, dec_stall=0.
  - Reset mid-operation discards all pending scoreboard state.
- Write-port latency is 0: the grant and ad3/wd3/we3 are valid in the same cycle. The register file commits on the following negedge.
- Scoreboard updates are visible one cycle after the handshake.
- Worst-case LLU wait is STARVE_LIMIT cycles plus the FORCE cycle. The forced grant happens in cycle STARVE_LIMIT+1 of continuous valid.
- Writeback to x0 is not a request, so the LLU can be granted in that cycle.

## Test plan
- Reset with rst_n=0 for 2 cycles while issue_valid=1 → all outputs 0. On the first cycle after release, issue_ready=1 and busy=0.
- Issue rd=5, then decode rs1=5 used → dec_stall=1. LLU returns x5=0xDEADBEEF in an idle pipe cycle → we3=1, ad3=5, wd3=0xDEADBEEF that cycle; dec_stall=0 the next cycle.
- pipe_we=1 rd=3 every cycle while LLU holds a result for x7, STARVE_LIMIT=8:
  - cycles 1–8: pipe writes x3, llu_ready=0;
  - cycle 9: FORCE with pipe_hold=1, ad3=7, llu_ready=1;
  - cycle 10: pipe write to x3 resumes.
- Issue rd=1..4 back-to-back → 4 accepted. The 5th issue (rd=6) sees issue_ready=0 until one result retires.
- Issue rd=9 twice → second issue_ready=0 (WAW). A decode write to x9 with dec_we=1 → dec_stall=1.
- LLU result with llu_rd=0 during pipe writeback of x2 → llu_ready=0 until the pipe is idle. On grant, we3=0 and the scoreboard is unchanged.
